// File: rtl/rca_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial wide adder: slice width, FSM states
// and the elaboration-time width legality check.
package rca_nibble_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/rca_nibble_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the
// nibble sequencer (slave).
interface rca_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_nibble_sequencer_rca4_slice.sv
// Combinational 4-bit ripple-carry adder made of four full-adder cells; also
// exposes the carry into bit 3 so the caller can form signed overflow.
module rca4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[4];
    assign c3 = c[3];
endmodule

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: accepts one operand pair, adds it one nibble per
// clock through a single 4-bit ripple slice, then holds the result until taken.
module rca_nibble_sequencer
    import rca_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rca_nibble_sequencer_if.slave  bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("rca_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       x_nib, y_nib, s_nib;
    logic             slice_co, slice_c3;
    logic             last_nib;

    // Select the nibble pair addressed by the pass counter.
    always_comb begin
        x_nib = '0;
        y_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                x_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                y_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    rca4_slice u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (slice_co),
        .c3 (slice_c3)
    );

    assign last_nib = (cnt_q == CNT_W'(NIB - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NIB; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*NIBBLE_W +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = slice_co;
                if (last_nib) begin
                    // The slice's bit 3 is the operand MSB on the final pass.
                    cout_d  = slice_co;
                    ovf_d   = slice_c3 ^ slice_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Bench for the nibble-serial adder: 16-bit and 4-bit instances driven with
// directed and random operands, results compared against plain arithmetic.
module tb_rca_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    rca_nibble_sequencer_if #(.WIDTH(16)) b16 ();
    rca_nibble_sequencer_if #(.WIDTH(4))  b4 ();

    rca_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    rca_nibble_sequencer #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Returns {ovf, cout, sum} for a w-bit add.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned full = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
        logic [15:0] s = 16'(full & mask);
        logic co = full[w];
        logic ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic present16(input logic [15:0] a, input logic [15:0] b, input logic c);
        b16.a = a; b16.b = b; b16.cin = c; b16.in_valid = 1'b1;
        @(negedge clk);
        b16.in_valid = 1'b0;
    endtask

    // Called on the first falling edge after the accept edge.
    task automatic result16(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c);
        logic [17:0] e = ref_add(16, a, b, c);
        int n = 0;
        while (b16.out_valid !== 1'b1 && n < 20) begin
            chk({tag, "_busy_in_ready"}, 32'(b16.in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_in_ready_done"}, 32'(b16.in_ready), 32'd0);
        chk({tag, "_sum"}, 32'(b16.sum), 32'(e[15:0]));
        chk({tag, "_cout"}, 32'(b16.cout), 32'(e[16]));
        chk({tag, "_ovf"}, 32'(b16.ovf), 32'(e[17]));
    endtask

    task automatic release16(input string tag);
        b16.out_ready = 1'b1;
        @(negedge clk);
        b16.out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, 32'(b16.in_ready), 32'd1);
        chk({tag, "_idle_out_valid"}, 32'(b16.out_valid), 32'd0);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
        chk({tag, "_ready_before"}, 32'(b16.in_ready), 32'd1);
        present16(a, b, c);
        result16(tag, a, b, c);
        release16(tag);
    endtask

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c);
        logic [17:0] e = ref_add(4, 16'(a), 16'(b), c);
        int n = 0;
        b4.a = a; b4.b = b; b4.cin = c; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        while (b4.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd1);
        chk({tag, "_sum"}, 32'(b4.sum), 32'(e[3:0]));
        chk({tag, "_cout"}, 32'(b4.cout), 32'(e[16]));
        chk({tag, "_ovf"}, 32'(b4.ovf), 32'(e[17]));
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, 32'(b4.in_ready), 32'd1);
    endtask

    initial begin
        logic [17:0] held;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.out_ready = 1'b0;
        b4.in_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0; b4.out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(b16.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
        chk("rst_sum", 32'(b16.sum), 32'd0);
        chk("rst_cout", 32'(b16.cout), 32'd0);
        chk("rst_ovf", 32'(b16.ovf), 32'd0);
        chk("rst4_in_ready", 32'(b4.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        op16("basic", 16'h0001, 16'h0002, 1'b0);
        op16("ripple", 16'hFFFF, 16'h0000, 1'b1);
        op16("posovf", 16'h7FFF, 16'h0001, 1'b0);
        op16("negovf", 16'h8000, 16'h8000, 1'b0);

        // Backpressure: result must stay frozen while the consumer stalls.
        present16(16'h1111, 16'h2222, 1'b0);
        result16("bp", 16'h1111, 16'h2222, 1'b0);
        held = ref_add(16, 16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            b16.in_valid = i[0];
            b16.a = 16'($urandom);
            b16.b = 16'($urandom);
            b16.cin = 1'($urandom);
            @(negedge clk);
            chk("bp_hold_sum", 32'(b16.sum), 32'(held[15:0]));
            chk("bp_hold_cout", 32'(b16.cout), 32'(held[16]));
            chk("bp_hold_ovf", 32'(b16.ovf), 32'(held[17]));
            chk("bp_hold_valid", 32'(b16.out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(b16.in_ready), 32'd0);
        end
        b16.in_valid = 1'b1; b16.a = 16'h0F0F; b16.b = 16'h0101; b16.cin = 1'b1;
        b16.out_ready = 1'b1;
        @(negedge clk);
        b16.out_ready = 1'b0;
        chk("bp_idle_gap", 32'(b16.in_ready), 32'd1);
        chk("bp_sum_kept", 32'(b16.sum), 32'(held[15:0]));
        @(negedge clk);
        b16.in_valid = 1'b0;
        result16("bp_next", 16'h0F0F, 16'h0101, 1'b1);
        release16("bp_next");

        // Reset in the middle of the third nibble pass.
        present16(16'hAAAA, 16'h5555, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(b16.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(b16.out_valid), 32'd0);
        chk("midrst_sum", 32'(b16.sum), 32'd0);
        chk("midrst_cout", 32'(b16.cout), 32'd0);
        chk("midrst_ovf", 32'(b16.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op16("after_rst", 16'h1234, 16'h4321, 1'b0);
        chk("after_rst_value", 32'(b16.sum), 32'h5555);

        op4("w4_carry", 4'hC, 4'hC, 1'b1);
        op4("w4_ovf", 4'h7, 4'h7, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            op4("rnd4", 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
